rails_dispatcher: RTL and testbench

Transmit-side companion to the rails permutation checker. Accepts a stream of station push/pop operations, simulates the station stack, and records the resulting departure order. Then serialises that order onto the checker-side input format: one `number` beat followed by `number` data beats. Sits upstream of the checker in the test/stimulus path and in any system that must announce a train order.

---
 rtl/rails_dispatcher.sv | 191 +++++++++++++++++++
 tb/tb_rails_dispatcher.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rails_dispatcher.sv
// rails_dispatcher: runs station push/pop ops on a car stack, then sends the departure count and departure order.
// Optional macro RAILS_DISPATCHER_ERR_EN: illegal ops or a non-empty stack abort the sequence with an err pulse.
module rails_dispatcher #(
    parameter int MAX_CARS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    input  logic       op_push,
    input  logic       op_last,
    output logic       op_ready,
    output logic       num_valid,
    output logic [3:0] number,
    output logic       data_valid,
    output logic [3:0] data,
    output logic       busy,
    output logic       err
);
    typedef enum logic [2:0] {
        S_COLLECT   = 3'd0,
        S_FLUSH     = 3'd1,
        S_SEND_NUM  = 3'd2,
        S_SEND_DATA = 3'd3,
        S_ABORT     = 3'd4,
        S_CLEAR     = 3'd5
    } state_t;

    // next_id carries one extra bit so MAX_CARS+1 stays representable when MAX_CARS = 15
    localparam logic [4:0] ID_LIMIT = 5'(MAX_CARS + 1);

    state_t     state_q;
    logic [3:0] stack_q [MAX_CARS];
    logic [3:0] dep_q   [MAX_CARS];
    logic [3:0] sp_q;
    logic [3:0] dcnt_q;
    logic [3:0] k_q;
    logic [4:0] next_id_q;
    logic       num_valid_q;
    logic [3:0] number_q;
    logic       data_valid_q;
    logic [3:0] data_q;
`ifdef RAILS_DISPATCHER_ERR_EN
    logic       bad_q;
    logic       bad_d;
    logic       illegal;
    logic       err_q;
`endif

    logic       accept;
    logic       push_ok;
    logic       pop_ok;
    logic [3:0] top_idx;
    logic [3:0] top_car;
    logic [3:0] sp_d;
    logic [3:0] dcnt_d;

    always_comb begin
        accept  = op_valid && (state_q == S_COLLECT);
        push_ok = op_push && (next_id_q != ID_LIMIT);
        pop_ok  = !op_push && (sp_q != 4'd0);
        top_idx = (sp_q == 4'd0) ? 4'd0 : sp_q - 4'd1;
        top_car = stack_q[top_idx];
        sp_d    = sp_q;
        dcnt_d  = dcnt_q;
        if (accept && push_ok) begin
            sp_d = sp_q + 4'd1;
        end else if (accept && pop_ok) begin
            sp_d   = sp_q - 4'd1;
            dcnt_d = dcnt_q + 4'd1;
        end
`ifdef RAILS_DISPATCHER_ERR_EN
        illegal = accept && !push_ok && !pop_ok;
        bad_d   = bad_q | illegal;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_COLLECT;
            sp_q         <= 4'd0;
            dcnt_q       <= 4'd0;
            k_q          <= 4'd0;
            next_id_q    <= 5'd1;
            num_valid_q  <= 1'b0;
            number_q     <= 4'd0;
            data_valid_q <= 1'b0;
            data_q       <= 4'd0;
`ifdef RAILS_DISPATCHER_ERR_EN
            bad_q        <= 1'b0;
            err_q        <= 1'b0;
`endif
            for (int i = 0; i < MAX_CARS; i++) begin
                stack_q[i] <= 4'd0;
                dep_q[i]   <= 4'd0;
            end
        end else begin
            num_valid_q  <= 1'b0;
            number_q     <= 4'd0;
            data_valid_q <= 1'b0;
            data_q       <= 4'd0;
`ifdef RAILS_DISPATCHER_ERR_EN
            err_q        <= 1'b0;
`endif
            case (state_q)
                S_COLLECT: begin
                    if (accept) begin
                        // illegal ops fall through both branches and leave the stack untouched
                        if (push_ok) begin
                            stack_q[sp_q] <= next_id_q[3:0];
                            next_id_q     <= next_id_q + 5'd1;
                        end else if (pop_ok) begin
                            dep_q[dcnt_q] <= top_car;
                        end
                        sp_q   <= sp_d;
                        dcnt_q <= dcnt_d;
`ifdef RAILS_DISPATCHER_ERR_EN
                        bad_q  <= bad_d;
                        if (op_last) begin
                            state_q <= (bad_d || (sp_d != 4'd0)) ? S_ABORT : S_SEND_NUM;
                        end
`else
                        if (op_last) begin
                            state_q <= (sp_d != 4'd0) ? S_FLUSH : S_SEND_NUM;
                        end
`endif
                    end
                end
                S_FLUSH: begin
                    if (sp_q != 4'd0) begin
                        dep_q[dcnt_q] <= top_car;
                        sp_q          <= sp_q - 4'd1;
                        dcnt_q        <= dcnt_q + 4'd1;
                    end
                    if (sp_q <= 4'd1) begin
                        state_q <= S_SEND_NUM;
                    end
                end
                S_SEND_NUM: begin
                    num_valid_q <= 1'b1;
                    number_q    <= dcnt_q;
                    k_q         <= 4'd0;
                    state_q     <= (dcnt_q != 4'd0) ? S_SEND_DATA : S_CLEAR;
                end
                S_SEND_DATA: begin
                    data_valid_q <= 1'b1;
                    data_q       <= dep_q[k_q];
                    k_q          <= k_q + 4'd1;
                    if (k_q == dcnt_q - 4'd1) begin
                        state_q <= S_CLEAR;
                    end
                end
                S_ABORT: begin
`ifdef RAILS_DISPATCHER_ERR_EN
                    err_q <= 1'b1;
`endif
                    state_q <= S_CLEAR;
                end
                S_CLEAR: begin
                    sp_q      <= 4'd0;
                    dcnt_q    <= 4'd0;
                    k_q       <= 4'd0;
                    next_id_q <= 5'd1;
`ifdef RAILS_DISPATCHER_ERR_EN
                    bad_q     <= 1'b0;
`endif
                    for (int i = 0; i < MAX_CARS; i++) begin
                        stack_q[i] <= 4'd0;
                        dep_q[i]   <= 4'd0;
                    end
                    state_q <= S_COLLECT;
                end
                default: begin
                    state_q <= S_COLLECT;
                end
            endcase
        end
    end

    assign op_ready   = (state_q == S_COLLECT);
    assign busy       = (state_q != S_COLLECT);
    assign num_valid  = num_valid_q;
    assign number     = number_q;
    assign data_valid = data_valid_q;
    assign data       = data_q;
`ifdef RAILS_DISPATCHER_ERR_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_rails_dispatcher.sv
// Bench for rails_dispatcher: directed and random op sequences checked against a queue-based station model.
module tb_rails_dispatcher;
    localparam int MAXC = 10;
`ifdef RAILS_DISPATCHER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_push  = 1'b0;
    logic       op_last  = 1'b0;
    logic       op_ready;
    logic       num_valid;
    logic [3:0] number;
    logic       data_valid;
    logic [3:0] data;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    rails_dispatcher #(.MAX_CARS(MAXC)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_push    (op_push),
        .op_last    (op_last),
        .op_ready   (op_ready),
        .num_valid  (num_valid),
        .number     (number),
        .data_valid (data_valid),
        .data       (data),
        .busy       (busy),
        .err        (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: plain stack of car ids, departures appended in order.
    task automatic model(input logic [31:0] ops, input int n,
                         output bit exp_err, output int exp_n, output int flush);
        int stk[$];
        int dep[$];
        int nid;
        bit bad;
        nid = 1;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (ops[i]) begin
                if (nid <= MAXC) begin
                    stk.push_back(nid);
                    nid++;
                end else begin
                    bad = 1'b1;
                end
            end else begin
                if (stk.size() > 0) dep.push_back(stk.pop_back());
                else bad = 1'b1;
            end
        end
        exp_err = ERR_EN && (bad || (stk.size() != 0));
        flush   = ERR_EN ? 0 : stk.size();
        if (!ERR_EN) begin
            while (stk.size() > 0) dep.push_back(stk.pop_back());
        end
        exp_q.delete();
        exp_n = exp_err ? 0 : dep.size();
        if (!exp_err) begin
            foreach (dep[k]) exp_q.push_back(4'(dep[k]));
        end
    endtask

    // Driver: ops with random idle gaps; op_last without op_valid is thrown in as noise.
    task automatic drive_ops(input logic [31:0] ops, input int n, input int gap_max, input string name);
        for (int i = 0; i < n; i++) begin
            int g;
            int w;
            g = $urandom_range(0, gap_max);
            for (int j = 0; j < g; j++) begin
                op_valid = 1'b0;
                op_push  = 1'($urandom_range(0, 1));
                op_last  = 1'($urandom_range(0, 1));
                tick();
            end
            w = 0;
            while (op_ready !== 1'b1 && w < 50) begin
                op_valid = 1'b0;
                tick();
                w++;
            end
            if (i == 0) chk({name, "_ready_at_start"}, op_ready, 1);
            op_valid = 1'b1;
            op_push  = ops[i];
            op_last  = (i == n - 1);
            tick();
        end
        op_valid = 1'b0;
        op_last  = 1'b0;
    endtask

    // Monitor + scoreboard: called right after the op_last acceptance edge (cycle 0).
    task automatic monitor(input bit exp_err, input int exp_n, input int flush, input string name);
        int num_cnt;
        int num_val;
        int err_cnt;
        int err_cyc;
        int rdy_cyc;
        int beat_cyc[$];
        logic [3:0] beat_dat[$];
        int nb;
        num_cnt = 0;
        num_val = -1;
        err_cnt = 0;
        err_cyc = -1;
        rdy_cyc = -1;
        chk({name, "_busy_after_last"}, busy, 1);
        for (int c = 0; c < 60; c++) begin
            if (c > 0) tick();
            if (num_valid === 1'b1) begin
                num_cnt++;
                num_val = number;
                chk({name, "_num_cycle"}, c, 1 + flush);
            end
            if (data_valid === 1'b1) begin
                beat_cyc.push_back(c);
                beat_dat.push_back(data);
            end
            if (err === 1'b1) begin
                err_cnt++;
                err_cyc = c;
            end
            if (op_ready === 1'b1) begin
                rdy_cyc = c;
                break;
            end
            // ops offered while busy must be ignored
            op_valid = 1'($urandom_range(0, 1));
            op_push  = 1'($urandom_range(0, 1));
            op_last  = 1'($urandom_range(0, 1));
        end
        op_valid = 1'b0;
        op_last  = 1'b0;
        chk({name, "_ready_returned"}, (rdy_cyc >= 0), 1);
        nb = beat_dat.size();
        if (exp_err) begin
            chk({name, "_err_count"}, err_cnt, 1);
            chk({name, "_err_cycle"}, err_cyc, 1);
            chk({name, "_num_count"}, num_cnt, 0);
            chk({name, "_beat_count"}, nb, 0);
            chk({name, "_ready_cycle"}, rdy_cyc, 2);
        end else begin
            chk({name, "_err_count"}, err_cnt, 0);
            chk({name, "_num_count"}, num_cnt, 1);
            chk({name, "_number"}, num_val, exp_n);
            chk({name, "_beat_count"}, nb, exp_n);
            for (int k = 0; k < nb && exp_q.size() > 0; k++) begin
                chk({name, "_data"}, beat_dat[k], exp_q.pop_front());
                chk({name, "_data_cycle"}, beat_cyc[k], 2 + flush + k);
            end
            chk({name, "_ready_cycle"}, rdy_cyc, 2 + flush + exp_n);
        end
        exp_q.delete();
    endtask

    task automatic run_seq(input logic [31:0] ops, input int n, input int gap_max, input string name);
        bit exp_err;
        int exp_n;
        int flush;
        model(ops, n, exp_err, exp_n, flush);
        drive_ops(ops, n, gap_max, name);
        monitor(exp_err, exp_n, flush, name);
    endtask

    initial begin
        int seen;
        int w;
        logic [31:0] rops;
        int rn;

        // reset state
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_num_valid", num_valid, 0);
        chk("rst_number", number, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_data", data, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        tick();
        chk("rst_op_ready", op_ready, 1);

        // directed sequences (bit i = 1 means push)
        run_seq(32'b010101, 6, 0, "alt_pp");
        run_seq(32'b000111, 6, 2, "push3_pop3");
        run_seq(32'b001011, 6, 1, "mixed");
        run_seq(32'b0, 1, 0, "pop_empty");
        run_seq(32'h0000_1FFF, 14, 0, "overflow");
        run_seq(32'b011, 3, 0, "flush2");
        run_seq(32'h0000_03FF, 20, 0, "full_stack");

        // reset during SEND_DATA after the second beat
        drive_ops(32'b010101, 6, 0, "mid_rst");
        seen = 0;
        w = 0;
        while (seen < 2 && w < 40) begin
            if (data_valid === 1'b1) seen++;
            if (seen < 2) begin
                tick();
                w++;
            end
        end
        chk("mid_rst_beats_seen", seen, 2);
        reset = 1'b0;
        tick();
        chk("mid_rst_data_valid", data_valid, 0);
        chk("mid_rst_num_valid", num_valid, 0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_data_valid", data_valid, 0);
            chk("post_rst_op_ready", op_ready, 1);
        end
        run_seq(32'b01, 2, 0, "after_rst");

        // randomized sequences
        for (int s = 0; s < 40; s++) begin
            rn = $urandom_range(1, 20);
            rops = '0;
            for (int i = 0; i < rn; i++) rops[i] = ($urandom_range(0, 99) < 60);
            run_seq(rops, rn, $urandom_range(0, 2), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
